// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS tuning word from a start value by a fixed
// increment over N points, holding each point for D cycles and strobing the settled cycle.
module dds_sweep_ctrl #(
    parameter int IDX_WIDTH   = 12,
    parameter int DWELL_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [31:0]            cfg_f_start,
    input  logic [31:0]            cfg_f_step,
    input  logic [IDX_WIDTH-1:0]   cfg_n_points,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    output logic [31:0]            freq,
    output logic [IDX_WIDTH-1:0]   point_idx,
    output logic                   point_valid,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             state;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [DWELL_WIDTH-1:0] dwell_last;
    logic [IDX_WIDTH-1:0]   idx_last;
    logic [31:0]            step;

    // Shadows hold N-1 and D-1 so a zero count collapses to a single point/cycle.
    assign point_valid = (state == S_RUN) && (dwell_cnt == dwell_last);
    assign busy        = (state == S_RUN);
    assign done        = (state == S_DONE);
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            freq       <= '0;
            point_idx  <= '0;
            dwell_cnt  <= '0;
            dwell_last <= '0;
            idx_last   <= '0;
            step       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        idx_last   <= (cfg_n_points == '0) ? '0 : cfg_n_points - IDX_WIDTH'(1);
                        dwell_last <= (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_WIDTH'(1);
                        step       <= cfg_f_step;
                        freq       <= cfg_f_start;
                        point_idx  <= '0;
                        dwell_cnt  <= '0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Abort leaves freq and point_idx where they are so the DDS keeps that tone.
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (dwell_cnt == dwell_last) begin
                        if (point_idx != idx_last) begin
                            freq      <= freq + step;
                            point_idx <= point_idx + IDX_WIDTH'(1);
                            dwell_cnt <= '0;
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer that generates the 32-bit frequency control word driving the DDS phase-accumulator stage's `Freq` input. On a start pulse it steps the tuning word from a start value by a fixed increment over N points, holding each point for a programmable dwell. It flags the settled point with a strobe so the downstream ADC capture and amplitude measurement can sample each point. It sits between the control-register or MCU interface and the DDS phase accumulator, in the same clock domain.

## Interface
Parameters:
- `IDX_WIDTH`, 12: width of the point counter and `cfg_n_points`; up to 4095 points.
- `DWELL_WIDTH`, 24: width of the dwell counter and `cfg_dwell`.

Ports:
- `clk`  in  1  system clock; the single clock for the block, shared with the DDS stage.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  sweep request, sampled in IDLE only.
- `abort`  in  1  terminate the sweep; sampled in RUN and IDLE.
- `cfg_f_start`  in  32  tuning word of point 0.
- `cfg_f_step`  in  32  unsigned tuning-word increment per point.
- `cfg_n_points`  in  IDX_WIDTH  number of points; 0 is treated as 1.
- `cfg_dwell`  in  DWELL_WIDTH  cycles per point; 0 is treated as 1.
- `freq`  out  32  frequency control word to the DDS `Freq` input.
- `point_idx`  out  IDX_WIDTH  index of the current point.
- `point_valid`  out  1  high in the last dwell cycle of each point.
- `busy`  out  1  high while the FSM is in RUN.
- `done`  out  1  one-cycle pulse after a sweep completes normally.

## Operation
- FSM states are IDLE, RUN and DONE. Every output is a register or a decode of registers only; there is no combinational path from any input to any output.
- **IDLE:**
  - If `start`=1 and `abort`=0: latch `cfg_*` into shadow registers as N=max(n,1) and D=max(dwell,1), load `freq`=`cfg_f_start`, `point_idx`=0 and dwell counter=0, then go to RUN.
  - If `start` and `abort` are both high, abort wins and `start` is ignored.
- **RUN:**
  - The dwell counter increments each cycle.
  - `point_valid` = (dwell counter == D-1).
  - At the end of a `point_valid` cycle, if `point_idx` < N-1: `freq` <= `freq` + step (mod 2^32; wrap is silent), `point_idx` +1, and dwell counter <= 0.
  - At the end of the `point_valid` cycle of point N-1: go to DONE. `freq` and `point_idx` hold.
- **DONE:** lasts exactly one cycle with `done`=1 and `busy`=0, then returns to IDLE. `start` is ignored in DONE.
- **Abort:** `abort` sampled high in RUN sends the FSM to IDLE on the next cycle. No `done` pulse is issued, and `freq` and `point_idx` hold their current values.
- **Config changes:** changes to `cfg_*` while RUN or DONE have no effect. Only the value at the accepted `start` is used.
- **After a sweep:** `freq` keeps its last value in IDLE. The DDS therefore keeps running at the final point until the next start or reset.
- **Reset:** `rst` has priority over everything, including mid-sweep. The cycle after `rst` is sampled, all outputs are 0: `freq`=0, `point_idx`=0, `point_valid`=0, `busy`=0, `done`=0, and state is IDLE.

## Timing
- `start` sampled at edge k: from cycle k+1, `busy`=1, `freq`=f_start and `point_idx`=0.
- Each point occupies exactly D cycles. `point_valid` is high in the D-th of them, or in every cycle when D=1.
- A new `freq` value appears in the cycle after the `point_valid` cycle.
- The total RUN duration is N·D cycles. `done` is asserted in cycle k+1+N·D. The earliest cycle in which a new `start` can be accepted is k+2+N·D.
- `busy` and `point_valid` are never high outside RUN. `done` and `busy` are never high together.
- The DDS stage registers `freq` into its accumulator one cycle later. The DDS stage accounts for that latency, not this block.

## Test plan
- **Basic sweep:** f_start=100, step=50, N=3, D=2, start at edge 0.
  - `freq` over cycles 1..6 = 100,100,150,150,200,200.
  - `point_valid` in cycles 2,4,6 with `point_idx` 0,1,2.
  - `done` in cycle 7; `busy` in cycles 1..6; `freq` stays 200 afterwards.
- **Wrap-around:** f_start=0xFFFFFFF0, step=0x20, N=2, D=1.
  - `freq` = 0xFFFFFFF0 then 0x00000010.
  - `point_valid` high in both cycles; `done` in cycle 3.
- **Zero config:** N=0, D=0, f_start=7.
  - One RUN cycle with `freq`=7 and `point_valid`=1, then `done` the next cycle.
- **Abort mid-sweep:** N=4, D=3, `abort` during point 1, dwell cycle 2.
  - `busy` drops the next cycle; no `done`; `freq` holds at f_start+step; `point_valid` does not fire for point 1.
  - `start` together with `abort` in IDLE is ignored.
- **Ignored inputs:** pulse `start` and change every `cfg_*` while busy.
  - The trace is identical to the unperturbed sweep.
  - `start` in the DONE cycle is ignored; `start` in the following cycle is accepted.
- **Reset mid-sweep:** assert `rst` in RUN at point 2.
  - The next cycle, all outputs are 0 and state is IDLE.
  - A fresh `start` then repeats the basic-sweep trace exactly.
